// File: rtl/dcache_controller_if.sv
// dcache_controller_if
//   Bundles the CPU data port and the 32-bit block-memory port of the data
//   cache into one interface.
//   CPU side   : read, write, address[7:0], writedata[7:0] -> cache
//                readdata[7:0], busywait                   <- cache
//   Memory side: mem_read, mem_write, mem_address[5:0],
//                mem_writedata[31:0]                       <- cache
//                mem_readdata[31:0], mem_busywait          -> cache
//   Modports: slave  = the cache controller itself
//             master = the environment (CPU + block memory) driving it
//
// Handshake: a CPU request (read or write high) is accepted at the first
// rising edge where busywait is 0; until then the CPU holds address, read,
// write and writedata stable. A memory strobe (mem_read or mem_write) is
// complete at the first rising edge where mem_busywait is 0; the cache holds
// the strobe, mem_address and mem_writedata stable until then.
interface dcache_controller_if;
   logic        read;
   logic        write;
   logic [7:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   modport slave (
      input  read, write, address, writedata, mem_readdata, mem_busywait,
      output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
   );

   modport master (
      output read, write, address, writedata, mem_readdata, mem_busywait,
      input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back data cache between the 8-bit CPU data port and
//   the 32-bit block memory. LINES lines of 4 bytes, each with tag, valid and
//   dirty state. Address split: tag [7:5], index [4:2], offset [1:0].
//   Ports:
//     clock     : rising-edge clock
//     reset_n   : asynchronous active-low reset
//     bus       : dcache_controller_if.slave (CPU port + block-memory port)
//     dbg_state : current FSM state (0 IDLE, 1 MEM_WRITE, 2 MEM_READ, 3 UPDATE)
module dcache_controller #(
   parameter int LINES       = 8,
   parameter int BLOCK_BYTES = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   dcache_controller_if.slave  bus,
   output logic [1:0]          dbg_state
);
   localparam int OW = $clog2(BLOCK_BYTES);
   localparam int IW = $clog2(LINES);
   localparam int TW = 8 - OW - IW;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MEM_WRITE = 2'd1,
      MEM_READ  = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   state_t         state;
   logic [31:0]    line_data [LINES];
   logic [TW-1:0]  line_tag  [LINES];
   logic [LINES-1:0] valid;
   logic [LINES-1:0] dirty;

   logic           mem_read_q;
   logic           mem_write_q;
   logic [5:0]     mem_address_q;
   logic [31:0]    mem_writedata_q;

   logic [TW-1:0]  req_tag;
   logic [IW-1:0]  req_index;
   logic [OW-1:0]  req_offset;
   logic [31:0]    sel_line;
   logic           request;
   logic           hit;
   logic           write_hit;
   logic           refill_done;

   assign req_tag    = bus.address[7 -: TW];
   assign req_index  = bus.address[OW +: IW];
   assign req_offset = bus.address[OW-1:0];
   assign sel_line   = line_data[req_index];
   assign request    = bus.read | bus.write;
   assign hit        = valid[req_index] && (line_tag[req_index] == req_tag);
   // write has priority over read, so any hit with write high is a store
   assign write_hit  = (state == IDLE) && bus.write && hit;
   assign refill_done = (state == MEM_READ) && !bus.mem_busywait;

   // readdata is forced to 0 on a miss so it reads 0 while reset clears valid
   assign bus.readdata  = hit ? sel_line[{req_offset, 3'b000} +: 8] : 8'h00;
   // reset_n gating makes busywait drop immediately even if the CPU holds a request
   assign bus.busywait  = reset_n & ((state != IDLE) | (request & !hit));
   assign bus.mem_read      = mem_read_q;
   assign bus.mem_write     = mem_write_q;
   assign bus.mem_address   = mem_address_q;
   assign bus.mem_writedata = mem_writedata_q;
   assign dbg_state         = state;

   // Line storage and tags carry no reset; valid bits guard their contents.
   // An aborted refill never reaches refill_done, so it leaves the line intact.
   always_ff @(posedge clock) begin
      if (refill_done) begin
         line_data[req_index] <= bus.mem_readdata;
         line_tag[req_index]  <= req_tag;
      end else if (write_hit) begin
         line_data[req_index][{req_offset, 3'b000} +: 8] <= bus.writedata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         valid           <= '0;
         dirty           <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_hit) begin
                  dirty[req_index] <= 1'b1;
               end else if (request && !hit) begin
                  if (dirty[req_index]) begin
                     // evict the resident block under its own tag
                     state           <= MEM_WRITE;
                     mem_write_q     <= 1'b1;
                     mem_address_q   <= {line_tag[req_index], req_index};
                     mem_writedata_q <= sel_line;
                  end else begin
                     state         <= MEM_READ;
                     mem_read_q    <= 1'b1;
                     mem_address_q <= {req_tag, req_index};
                  end
               end
            end
            MEM_WRITE: begin
               if (!bus.mem_busywait) begin
                  state           <= MEM_READ;
                  mem_write_q     <= 1'b0;
                  mem_writedata_q <= '0;
                  mem_read_q      <= 1'b1;
                  mem_address_q   <= {req_tag, req_index};
               end
            end
            MEM_READ: begin
               if (!bus.mem_busywait) begin
                  state            <= UPDATE;
                  valid[req_index] <= 1'b1;
                  dirty[req_index] <= 1'b0;
                  mem_read_q       <= 1'b0;
                  mem_address_q    <= '0;
               end
            end
            UPDATE: begin
               // the held request re-evaluates as a hit in IDLE
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] dbg_state;

   dcache_controller_if bus();

   dcache_controller dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] gold [256];

   // ---------------- block memory model ----------------
   logic [31:0] mem_blk [64];
   logic        mem_init = 1'b1;
   int          mem_lat = 2;
   int          mem_cnt = 0;

   function automatic logic [31:0] blk_init(input int i);
      logic [7:0] b;
      b = i[7:0];
      if (i == 9)  return 32'hDDCCBBAA;
      if (i == 41) return 32'h44332211;
      return {b ^ 8'h5C, b + 8'h11, ~b, b * 8'd3};
   endfunction

   // busy on every strobe cycle except the mem_lat-th one
   assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (mem_cnt < mem_lat - 1);
   assign bus.mem_readdata = mem_blk[bus.mem_address];

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem_blk[i] <= blk_init(i);
      end else if (bus.mem_write && !bus.mem_busywait) begin
         mem_blk[bus.mem_address] <= bus.mem_writedata;
      end
      if (!reset_n || !(bus.mem_read | bus.mem_write) || !bus.mem_busywait)
         mem_cnt <= 0;
      else
         mem_cnt <= mem_cnt + 1;
   end

   // ---------------- driver ----------------
   task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wdata, input string name,
                             output int stall, output logic saw_wr, output logic [5:0] wr_addr,
                             output logic [31:0] wr_data, output logic saw_rd,
                             output logic [5:0] rd_addr);
      logic both;
      logic [7:0] exp;
      @(posedge clock); #1;
      bus.read = rd; bus.write = wr; bus.address = addr; bus.writedata = wdata;
      if (wr) gold[addr] = wdata;
      else if (rd) exp_q.push_back(gold[addr]);
      stall = 0; saw_wr = 1'b0; saw_rd = 1'b0; both = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      @(negedge clock);
      while (bus.busywait === 1'b1 && stall < 300) begin
         if (bus.mem_write === 1'b1 && !saw_wr) begin
            saw_wr = 1'b1; wr_addr = bus.mem_address; wr_data = bus.mem_writedata;
         end
         if (bus.mem_read === 1'b1 && !saw_rd) begin
            saw_rd = 1'b1; rd_addr = bus.mem_address;
         end
         if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both = 1'b1;
         stall++;
         @(negedge clock);
      end
      checks++;
      if (bus.busywait !== 1'b0) begin
         errors++;
         $display("FAIL %s busywait_release: got %b after %0d cycles, expected 0", name, bus.busywait, stall);
      end
      checks++;
      if (both !== 1'b0) begin
         errors++;
         $display("FAIL %s strobe_exclusive: mem_read and mem_write both high, expected never", name);
      end
      if (rd && !wr && exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         checks++;
         if (bus.readdata !== exp) begin
            errors++;
            $display("FAIL %s readdata @%02h: got %02h expected %02h", name, addr, bus.readdata, exp);
         end
      end
      @(posedge clock); #1;
      bus.read = 1'b0; bus.write = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h00; bus.writedata = 8'h00;
      reset_n = 1'b0; mem_init = 1'b1; mem_lat = 3;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.busywait} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got rd/wr/busy=%b expected 000", {bus.mem_read, bus.mem_write, bus.busywait});
      end
      checks++;
      if (bus.mem_address !== 6'h00 || bus.mem_writedata !== 32'h0 || bus.readdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%02h wdata=%08h rdata=%02h expected zeros",
                  bus.mem_address, bus.mem_writedata, bus.readdata);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", dbg_state);
      end
      bus.read = 1'b0; mem_init = 1'b0; reset_n = 1'b1;
      cpu_access(1'b1, 1'b0, 8'h00, 8'h00, "reset_read0", st, sw, wa, wd, sr, ra);
      checks++;
      if (!sr || ra !== 6'h00 || sw || st != 2 + mem_lat) begin
         errors++;
         $display("FAIL reset_read0_miss: got rd=%b addr=%02h wr=%b stall=%0d expected rd=1 addr=00 wr=0 stall=%0d",
                  sr, ra, sw, st, 2 + mem_lat);
      end
   endtask

   task automatic test_clean_miss();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      mem_lat = 5;
      cpu_access(1'b1, 1'b0, 8'h25, 8'h00, "clean_miss", st, sw, wa, wd, sr, ra);
      checks++;
      if (!sr || ra !== 6'h09 || sw) begin
         errors++;
         $display("FAIL clean_miss_mem: got rd=%b addr=%02h wr=%b expected rd=1 addr=09 wr=0", sr, ra, sw);
      end
      checks++;
      if (st != 7) begin
         errors++;
         $display("FAIL clean_miss_stall: got %0d expected 7", st);
      end
   endtask

   task automatic test_write_hit();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      cpu_access(1'b0, 1'b1, 8'h26, 8'h5A, "write_hit", st, sw, wa, wd, sr, ra);
      checks++;
      if (st != 0 || sw || sr) begin
         errors++;
         $display("FAIL write_hit_stall: got stall=%0d rd=%b wr=%b expected 0 0 0", st, sr, sw);
      end
      cpu_access(1'b1, 1'b0, 8'h26, 8'h00, "read_after_write", st, sw, wa, wd, sr, ra);
      checks++;
      if (st != 0) begin
         errors++;
         $display("FAIL read_after_write_stall: got %0d expected 0", st);
      end
      cpu_access(1'b1, 1'b0, 8'h25, 8'h00, "read_neighbour", st, sw, wa, wd, sr, ra);
   endtask

   task automatic test_dirty_eviction();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      mem_lat = 3;
      cpu_access(1'b1, 1'b0, 8'hA5, 8'h00, "dirty_evict", st, sw, wa, wd, sr, ra);
      checks++;
      if (!sw || wa !== 6'h09 || wd !== 32'hDD5ABBAA) begin
         errors++;
         $display("FAIL dirty_evict_wb: got wr=%b addr=%02h data=%08h expected 1 09 DD5ABBAA", sw, wa, wd);
      end
      checks++;
      if (!sr || ra !== 6'h29) begin
         errors++;
         $display("FAIL dirty_evict_refill: got rd=%b addr=%02h expected 1 29", sr, ra);
      end
      checks++;
      if (st != 8) begin
         errors++;
         $display("FAIL dirty_evict_stall: got %0d expected 8", st);
      end
   endtask

   task automatic test_reset_mid_refill();
      int st, guard; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      mem_lat = 6;
      @(posedge clock); #1;
      bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h50;
      guard = 0;
      @(negedge clock);
      while (bus.mem_read !== 1'b1 && guard < 20) begin
         guard++;
         @(negedge clock);
      end
      checks++;
      if (bus.mem_read !== 1'b1) begin
         errors++;
         $display("FAIL midrefill_start: got mem_read=%b expected 1", bus.mem_read);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.busywait} !== 3'b000 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL midrefill_abort: got rd/wr/busy=%b state=%0d expected 000 state 0",
                  {bus.mem_read, bus.mem_write, bus.busywait}, dbg_state);
      end
      @(posedge clock); #1;
      reset_n = 1'b1; bus.read = 1'b0;
      cpu_access(1'b1, 1'b0, 8'h50, 8'h00, "midrefill_reread", st, sw, wa, wd, sr, ra);
      checks++;
      if (!sr || ra !== 6'h14 || st != 2 + mem_lat) begin
         errors++;
         $display("FAIL midrefill_reread_miss: got rd=%b addr=%02h stall=%0d expected 1 14 %0d",
                  sr, ra, st, 2 + mem_lat);
      end
   endtask

   task automatic test_lane_sweep();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      logic [7:0] vals [4];
      vals[0] = 8'h10; vals[1] = 8'h21; vals[2] = 8'h32; vals[3] = 8'h43;
      mem_lat = 2;
      for (int k = 0; k < 4; k++)
         cpu_access(1'b0, 1'b1, 8'h60 + 8'(k), vals[k], "lane_write", st, sw, wa, wd, sr, ra);
      for (int k = 0; k < 4; k++)
         cpu_access(1'b1, 1'b0, 8'h60 + 8'(k), 8'h00, "lane_read", st, sw, wa, wd, sr, ra);
      cpu_access(1'b1, 1'b0, 8'h80, 8'h00, "lane_evict", st, sw, wa, wd, sr, ra);
      checks++;
      if (!sw || wa !== 6'h18 || wd !== 32'h43322110) begin
         errors++;
         $display("FAIL lane_evict: got wr=%b addr=%02h data=%08h expected 1 18 43322110", sw, wa, wd);
      end
   endtask

   task automatic test_rw_priority();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      cpu_access(1'b1, 1'b1, 8'h81, 8'hC3, "rw_both", st, sw, wa, wd, sr, ra);
      checks++;
      if (st != 0 || sw || sr) begin
         errors++;
         $display("FAIL rw_both_stall: got stall=%0d rd=%b wr=%b expected 0 0 0", st, sr, sw);
      end
      cpu_access(1'b1, 1'b0, 8'h81, 8'h00, "rw_readback", st, sw, wa, wd, sr, ra);
      cpu_access(1'b1, 1'b0, 8'h80, 8'h00, "rw_neighbour", st, sw, wa, wd, sr, ra);
   endtask

   task automatic test_back_to_back();
      int st; logic sw, sr; logic [5:0] wa, ra; logic [31:0] wd;
      logic [7:0] addr;
      logic [31:0] exp_blk;
      logic wr;
      for (int n = 0; n < 40; n++) begin
         mem_lat = $urandom_range(2, 4);
         addr = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
         wr = 1'($urandom_range(0, 1));
         cpu_access(~wr, wr, addr, 8'($urandom_range(0, 255)), "random", st, sw, wa, wd, sr, ra);
         if (sw) begin
            exp_blk = {gold[{wa, 2'd3}], gold[{wa, 2'd2}], gold[{wa, 2'd1}], gold[{wa, 2'd0}]};
            checks++;
            if (wd !== exp_blk) begin
               errors++;
               $display("FAIL random_writeback @%02h: got %08h expected %08h", wa, wd, exp_blk);
            end
         end
      end
   endtask

   initial begin
      logic [31:0] blk;
      for (int a = 0; a < 256; a++) begin
         blk = blk_init(a >> 2);
         gold[a] = blk[(a % 4) * 8 +: 8];
      end
      test_reset();
      test_clean_miss();
      test_write_hit();
      test_dirty_eviction();
      test_reset_mid_refill();
      test_lane_sweep();
      test_rw_priority();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end
endmodule
